baccarat_dealer: RTL and testbench

Sequencing engine that produces the card stream a hand scorer consumes. It pulls cards one at a time from a card source over a valid/req handshake and loads player and dealer card slots in baccarat order. It applies natural/third-card drawing rules and reports final scores and the winner. It sits between the card source (random dealer) and the score/7-seg display path.

---
 rtl/baccarat_pkg.sv | 29 ++
 rtl/baccarat_hand_score.sv | 24 ++
 rtl/baccarat_dealer.sv | 118 +++++++++++
 tb/tb_baccarat_dealer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat dealing engine.
// A card is a 4-bit face code (1..13); 0 marks an empty slot.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL,
    S_P3,
    S_DEC,
    S_D3,
    S_RESULT
  } state_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_MAX   = 4'd13;

  // Tens and court cards are worth nothing; an empty slot also scores 0.
  function automatic logic [3:0] card_value(input card_t card);
    if (card >= 4'd10) return 4'd0;
    return card;
  endfunction

endpackage

// File: rtl/baccarat_hand_score.sv
// Baccarat hand total: sum of three card values modulo 10.
// Purely combinational; empty slots contribute nothing.
module hand_score
  import baccarat_pkg::*;
(
  input  card_t       card1,
  input  card_t       card2,
  input  card_t       card3,
  output logic [3:0]  score
);

  logic [4:0] sum;
  logic [4:0] wrapped;

  // The raw sum never exceeds 27, so at most two subtractions of 10 finish the modulo.
  always_comb begin
    sum = 5'(card_value(card1)) + 5'(card_value(card2)) + 5'(card_value(card3));
    if (sum >= 5'd20)      wrapped = sum - 5'd20;
    else if (sum >= 5'd10) wrapped = sum - 5'd10;
    else                   wrapped = sum;
    score = wrapped[3:0];
  end

endmodule

// File: rtl/baccarat_dealer.sv
// Baccarat dealing sequencer: pulls cards over a valid/req handshake,
// fills player/dealer slots in dealing order, applies drawing rules and reports the winner.
module baccarat_dealer
  import baccarat_pkg::*;
#(
  parameter logic [3:0] NATURAL_MIN  = 4'd8,
  parameter logic [3:0] PLAYER_STAND = 4'd6
) (
  input  logic        slow_clock,
  input  logic        resetb,
  input  logic        start,
  input  card_t       card_in,
  input  logic        card_valid,
  output logic        card_req,
  output card_t       pcard1,
  output card_t       pcard2,
  output card_t       pcard3,
  output card_t       dcard1,
  output card_t       dcard2,
  output card_t       dcard3,
  output logic [3:0]  pscore,
  output logic [3:0]  dscore,
  output logic        done,
  output logic        player_win,
  output logic        dealer_win
);

  state_t      state, next_state;
  logic        clear_slots;
  logic        card_ok;
  logic        take_card;
  logic        dealer_draws;
  logic [3:0]  third_value;

  hand_score u_player_score (.card1(pcard1), .card2(pcard2), .card3(pcard3), .score(pscore));
  hand_score u_dealer_score (.card1(dcard1), .card2(dcard2), .card3(dcard3), .score(dscore));

  // Codes 0, 14 and 15 are consumed from the source but never stored.
  assign card_ok   = (card_in != CARD_EMPTY) && (card_in <= CARD_MAX);
  assign take_card = card_req && card_valid && card_ok;

  always_comb begin
    third_value  = card_value(pcard3);
    dealer_draws = 1'b0;
    if (pcard3 == CARD_EMPTY) begin
      dealer_draws = (dscore <= 4'd5);
    end else begin
      unique case (dscore)
        4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
        4'd3:             dealer_draws = (third_value != 4'd8);
        4'd4:             dealer_draws = (third_value >= 4'd2) && (third_value <= 4'd7);
        4'd5:             dealer_draws = (third_value >= 4'd4) && (third_value <= 4'd7);
        4'd6:             dealer_draws = (third_value >= 4'd6) && (third_value <= 4'd7);
        default:          dealer_draws = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    card_req    = 1'b0;
    clear_slots = 1'b0;
    unique case (state)
      S_IDLE, S_RESULT: begin
        if (start) begin
          clear_slots = 1'b1;
          next_state  = S_P1;
        end
      end
      S_P1: begin card_req = 1'b1; if (card_valid && card_ok) next_state = S_D1;     end
      S_D1: begin card_req = 1'b1; if (card_valid && card_ok) next_state = S_P2;     end
      S_P2: begin card_req = 1'b1; if (card_valid && card_ok) next_state = S_D2;     end
      S_D2: begin card_req = 1'b1; if (card_valid && card_ok) next_state = S_EVAL;   end
      S_P3: begin card_req = 1'b1; if (card_valid && card_ok) next_state = S_DEC;    end
      S_D3: begin card_req = 1'b1; if (card_valid && card_ok) next_state = S_RESULT; end
      S_EVAL: begin
        if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) next_state = S_RESULT;
        else if (pscore < PLAYER_STAND)                     next_state = S_P3;
        else                                                next_state = S_DEC;
      end
      S_DEC:   next_state = dealer_draws ? S_D3 : S_RESULT;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb || clear_slots) begin
      pcard1 <= CARD_EMPTY;
      pcard2 <= CARD_EMPTY;
      pcard3 <= CARD_EMPTY;
      dcard1 <= CARD_EMPTY;
      dcard2 <= CARD_EMPTY;
      dcard3 <= CARD_EMPTY;
    end else if (take_card) begin
      unique case (state)
        S_P1:    pcard1 <= card_in;
        S_D1:    dcard1 <= card_in;
        S_P2:    pcard2 <= card_in;
        S_D2:    dcard2 <= card_in;
        S_P3:    pcard3 <= card_in;
        S_D3:    dcard3 <= card_in;
        default: ;
      endcase
    end
  end

  assign done       = (state == S_RESULT);
  assign player_win = done && (pscore >= dscore);
  assign dealer_win = done && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_dealer.sv
// Self-checking bench for baccarat_dealer: directed hand table, handshake/reset
// corner sequences and random hands scored by a rule-level reference model.
module tb_baccarat_dealer;
  import baccarat_pkg::*;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic       start      = 1'b0;
  logic       card_valid = 1'b0;
  card_t      card_in    = '0;
  logic       card_req;
  card_t      pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       done, player_win, dealer_win;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 slow_clock = ~slow_clock;

  baccarat_dealer dut (
    .slow_clock(slow_clock), .resetb(resetb), .start(start),
    .card_in(card_in), .card_valid(card_valid), .card_req(card_req),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .done(done),
    .player_win(player_win), .dealer_win(dealer_win)
  );

  typedef struct {
    logic [5:0][3:0] cards;  // cards[0] is dealt first
    int              n;
    logic [11:0]     pc;     // {pcard1, pcard2, pcard3}
    logic [11:0]     dc;     // {dcard1, dcard2, dcard3}
    logic [3:0]      ps, ds;
    logic            pw, dw;
  } hand_t;

  hand_t vec[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  function automatic hand_t mk(input int c0, c1, c2, c3, c4, c5, input int n,
                               input int p1, p2, p3, d1, d2, d3,
                               input int ps, ds, input bit pw, dw);
    hand_t h;
    h.cards = {4'(c5), 4'(c4), 4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    h.n  = n;
    h.pc = {4'(p1), 4'(p2), 4'(p3)};
    h.dc = {4'(d1), 4'(d2), 4'(d3)};
    h.ps = 4'(ps);
    h.ds = 4'(ds);
    h.pw = pw;
    h.dw = dw;
    return h;
  endfunction

  // ---------------- reference model: the rules of baccarat, plainly ----------------
  function automatic int pts(input int c);
    return (c >= 10) ? 0 : c;
  endfunction

  function automatic int total(input int q[$]);
    int s = 0;
    foreach (q[i]) s += pts(q[i]);
    return s % 10;
  endfunction

  // v < 0 means the player stood on two cards.
  function automatic bit banker_draws(input int b, input int v);
    if (v < 0) return b <= 5;
    if (b <= 2) return 1;
    if (b == 3) return v != 8;
    if (b == 4) return v >= 2 && v <= 7;
    if (b == 5) return v >= 4 && v <= 7;
    if (b == 6) return v == 6 || v == 7;
    return 0;
  endfunction

  function automatic hand_t model(input logic [5:0][3:0] c);
    hand_t h;
    int p[$];
    int d[$];
    int k, ps, ds, v;
    p = '{int'(c[0]), int'(c[2])};
    d = '{int'(c[1]), int'(c[3])};
    k = 4;
    ps = total(p);
    ds = total(d);
    if (ps < 8 && ds < 8) begin
      v = -1;
      if (ps < 6) begin
        p.push_back(int'(c[k])); k++;
        v = pts(p[2]);
        ps = total(p);
      end
      if (banker_draws(ds, v)) begin
        d.push_back(int'(c[k])); k++;
        ds = total(d);
      end
    end
    while (p.size() < 3) p.push_back(0);
    while (d.size() < 3) d.push_back(0);
    h.cards = c;
    h.n  = k;
    h.pc = {4'(p[0]), 4'(p[1]), 4'(p[2])};
    h.dc = {4'(d[0]), 4'(d[1]), 4'(d[2])};
    h.ps = 4'(ps);
    h.ds = 4'(ds);
    h.pw = (ps >= ds);
    h.dw = (ds >= ps);
    return h;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic present(input card_t c, input bit noisy);
    card_t junk;
    if (noisy && $urandom_range(0, 2) == 0) begin
      card_valid = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      junk = card_t'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(14, 15));
      card_in = junk;
      card_valid = 1'b1;
      tick();
    end
    card_in = c;
    card_valid = 1'b1;
    tick();
    card_valid = 1'b0;
  endtask

  task automatic play(input hand_t h, input bit noisy, input string tag);
    int t;
    pulse_start();
    for (int i = 0; i < h.n; i++) begin
      t = 0;
      while (!card_req && !done && t < 20) begin tick(); t++; end
      if (!card_req) begin
        check($sformatf("%s card_req for card %0d", tag, i), {31'd0, card_req}, 32'd1);
        return;
      end
      present(h.cards[i], noisy);
    end
    t = 0;
    while (!card_req && !done && t < 20) begin tick(); t++; end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " no extra card_req"}, {31'd0, card_req}, 32'd0);
    check({tag, " pcards"}, {pcard1, pcard2, pcard3}, h.pc);
    check({tag, " dcards"}, {dcard1, dcard2, dcard3}, h.dc);
    check({tag, " scores"}, {pscore, dscore}, {h.ps, h.ds});
    check({tag, " winners"}, {player_win, dealer_win}, {h.pw, h.dw});
  endtask

  initial begin
    vec[0] = mk(4, 3, 5, 2, 0, 0,  4,  4, 5, 0,   3, 2, 0,   9, 5, 1, 0);
    vec[1] = mk(2, 3, 3, 13, 8, 0, 5,  2, 3, 8,   3, 13, 0,  3, 3, 1, 1);
    vec[2] = mk(1, 6, 2, 11, 7, 9, 6,  1, 2, 7,   6, 11, 9,  0, 5, 0, 1);
    vec[3] = mk(3, 2, 4, 1, 12, 0, 5,  3, 4, 0,   2, 1, 12,  7, 3, 1, 0);
    vec[4] = mk(10, 9, 5, 13, 0, 0, 4, 10, 5, 0,  9, 13, 0,  5, 9, 0, 1);
    vec[5] = mk(6, 7, 13, 10, 0, 0, 4, 6, 13, 0,  7, 10, 0,  6, 7, 0, 1);
    vec[6] = mk(1, 6, 1, 10, 4, 0, 5,  1, 1, 4,   6, 10, 0,  6, 6, 1, 1);

    // Reset state, then release with start low: must stay idle.
    repeat (3) tick();
    check("reset card_req", {31'd0, card_req}, 32'd0);
    check("reset done/wins", {29'd0, done, player_win, dealer_win}, 32'd0);
    check("reset slots", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 32'd0);
    resetb = 1'b1;
    repeat (3) tick();
    check("idle after release", {30'd0, card_req, done}, 32'd0);

    // Natural: done rises exactly one cycle after EVAL.
    pulse_start();
    present(4'd4, 0); present(4'd3, 0); present(4'd5, 0); present(4'd2, 0);
    check("natural EVAL cycle", {30'd0, card_req, done}, 32'd0);
    tick();
    check("natural done next cycle", {31'd0, done}, 32'd1);
    check("natural winners", {30'd0, player_win, dealer_win}, 32'd2);

    for (int i = 0; i < 7; i++) play(vec[i], 0, $sformatf("vec%0d", i));

    // In RESULT, start and a valid card together: start wins, card not stored.
    start = 1'b1; card_valid = 1'b1; card_in = 4'd9;
    tick();
    start = 1'b0; card_valid = 1'b0;
    check("restart in P1", {30'd0, card_req, done}, 32'd2);
    check("restart card not consumed", {pcard1, dcard1}, 32'd0);

    // Stall in P1, then an invalid code, then a real card.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall card_req %0d", i), {31'd0, card_req}, 32'd1);
    end
    card_in = 4'd14; card_valid = 1'b1;
    tick();
    check("code 14 discarded", {27'd0, card_req, pcard1}, {27'd0, 1'b1, 4'd0});
    card_in = 4'd5;
    tick();
    card_valid = 1'b0;
    check("pcard1 after stall", {28'd0, pcard1}, 32'd5);

    // Async reset between edges while waiting in D2.
    present(4'd3, 0); present(4'd1, 0);
    check("in D2 before reset", {pcard1, dcard1, pcard2, dcard2}, {4'd5, 4'd3, 4'd1, 4'd0});
    #3;
    resetb = 1'b0;
    card_in = 4'd7; card_valid = 1'b1;
    #1;
    check("async reset slots", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 32'd0);
    check("async reset card_req", {31'd0, card_req}, 32'd0);
    tick();
    card_valid = 1'b0;
    resetb = 1'b1;
    tick();
    check("card ignored during reset", {27'd0, card_req, dcard2}, 32'd0);
    play(vec[2], 0, "after reset");

    // Random hands with stalls and junk codes against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [5:0][3:0] c;
      for (int i = 0; i < 6; i++) c[i] = 4'($urandom_range(1, 13));
      play(model(c), 1, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
